// File: rtl/wish_pack_arb_if.sv
// Bus bundle between NUM_SRC Wishbone sources, the grant-locking arbiter and one wish_pack.
// slave = arbiter view, master = environment (sources + packer) view.
interface wish_pack_arb_if #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_PACK   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TGC_WIDTH  = 2
);
  localparam int CNT_W = $clog2(NUM_PACK) + 1;

  logic [NUM_SRC-1:0]            s_stb_i;
  logic [NUM_SRC-1:0]            s_cyc_i;
  logic [NUM_SRC*DATA_WIDTH-1:0] s_dat_i;
  logic [NUM_SRC*TGC_WIDTH-1:0]  s_tgc_i;
  logic [NUM_SRC-1:0]            s_ack_o;
  logic [NUM_SRC-1:0]            s_stall_o;
  logic                          m_stb_o;
  logic                          m_cyc_o;
  logic [DATA_WIDTH-1:0]         m_dat_o;
  logic [TGC_WIDTH-1:0]          m_tgc_o;
  logic                          m_ack_i;
  logic                          m_stall_i;
  logic [NUM_SRC-1:0]            gnt_o;
  logic [CNT_W-1:0]              beat_cnt_o;

  modport slave (
    input  s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, m_ack_i, m_stall_i,
    output s_ack_o, s_stall_o, m_stb_o, m_cyc_o, m_dat_o, m_tgc_o, gnt_o, beat_cnt_o
  );

  modport master (
    output s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, m_ack_i, m_stall_i,
    input  s_ack_o, s_stall_o, m_stb_o, m_cyc_o, m_dat_o, m_tgc_o, gnt_o, beat_cnt_o
  );
endinterface

// File: rtl/wish_pack_arb.sv
// Grant-locking round-robin arbiter in front of one wish_pack; a source owns the packer for a full group.
// Define WISH_PACK_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
module wish_pack_arb #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_PACK   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TGC_WIDTH  = 2
) (
  input logic           clk_i,
  input logic           rst_ni,
  wish_pack_arb_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(NUM_PACK) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] gnt_reg, gnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [NUM_SRC-1:0] req;
  logic               any_req;
  logic               m_stb;
  logic               beat_acc;
  logic               group_done;
  logic [IDX_W-1:0]   search_base;
  logic [IDX_W-1:0]   win_idx;
  logic               found;
  int                 cand;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NUM_SRC - 1)) ? '0 : x + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign req[gi]           = bus.s_stb_i[gi] & bus.s_cyc_i[gi];
    assign bus.s_ack_o[gi]   = gnt_reg[gi] & bus.m_ack_i;
    assign bus.s_stall_o[gi] = gnt_reg[gi] ? bus.m_stall_i : 1'b1;
  end

  assign any_req    = |req;
  assign beat_acc   = m_stb & bus.m_ack_i;
  assign group_done = beat_acc && (cnt_reg == CNT_W'(NUM_PACK - 1));

`ifdef WISH_PACK_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;

  // At a group boundary the finishing source drops to lowest priority on the same edge.
  assign search_base = (state_reg == GRANT) ? inc_wrap(idx_reg) : rr_ptr_reg;
`endif

  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = int'(search_base) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
`ifndef WISH_PACK_ARB_FIXED_PRIO_EN
      rr_ptr_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
`ifndef WISH_PACK_ARB_FIXED_PRIO_EN
      rr_ptr_reg <= rr_ptr_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
`ifndef WISH_PACK_ARB_FIXED_PRIO_EN
    rr_ptr_next = rr_ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = GRANT;
          idx_next   = win_idx;
          gnt_next   = NUM_SRC'(1) << win_idx;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (group_done) begin
          cnt_next = '0;
`ifndef WISH_PACK_ARB_FIXED_PRIO_EN
          rr_ptr_next = inc_wrap(idx_reg);
`endif
          if (any_req) begin
            idx_next = win_idx;
            gnt_next = NUM_SRC'(1) << win_idx;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (beat_acc) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // gnt_reg is zero in IDLE, so the AND-OR mux idles the packer side for free.
  always_comb begin
    m_stb       = |(gnt_reg & req);
    bus.m_cyc_o = (state_reg == GRANT);
    bus.m_dat_o = '0;
    bus.m_tgc_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.m_dat_o = bus.m_dat_o | ({DATA_WIDTH{gnt_reg[i]}} & bus.s_dat_i[i*DATA_WIDTH +: DATA_WIDTH]);
      bus.m_tgc_o = bus.m_tgc_o | ({TGC_WIDTH{gnt_reg[i]}} & bus.s_tgc_i[i*TGC_WIDTH +: TGC_WIDTH]);
    end
  end

  assign bus.m_stb_o    = m_stb;
  assign bus.gnt_o      = gnt_reg;
  assign bus.beat_cnt_o = cnt_reg;

  a_ack_stall_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.s_ack_o & bus.s_stall_o) == '0);
  a_ack_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.s_ack_o));
  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_reg));
endmodule

// File: tb/tb_wish_pack_arb.sv
// Directed bench for wish_pack_arb: single source, contention, mid-group gap, packer stall, async reset.
module tb_wish_pack_arb;
  localparam int NS = 4;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int TW = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  wish_pack_arb_if #(.NUM_SRC(NS), .NUM_PACK(NP), .DATA_WIDTH(DW), .TGC_WIDTH(TW)) bus ();

  wish_pack_arb #(.NUM_SRC(NS), .NUM_PACK(NP), .DATA_WIDTH(DW), .TGC_WIDTH(TW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic set_src(input int k, input logic on, input logic [DW-1:0] d);
    bus.s_stb_i[k]         = on;
    bus.s_cyc_i[k]         = on;
    bus.s_dat_i[k*DW +: DW] = d;
    bus.s_tgc_i[k*TW +: TW] = TW'(k);
  endtask

  task automatic clear_inputs();
    bus.s_stb_i   = '0;
    bus.s_cyc_i   = '0;
    bus.s_dat_i   = '0;
    bus.s_tgc_i   = '0;
    bus.m_ack_i   = 1'b0;
    bus.m_stall_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("rst_cnt", 32'(bus.beat_cnt_o), 32'h0);
    chk("rst_stall", 32'(bus.s_stall_o), 32'hf);
    chk("rst_cyc", 32'(bus.m_cyc_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] beats [4];
  logic [NS-1:0] exp_w;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear_inputs();
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;

    // Single source 2, four beats, acked every cycle.
    apply_reset();
    set_src(2, 1'b1, beats[0]);
    bus.m_ack_i = 1'b1;
    #1;
    chk("s1_gnt_lat", 32'(bus.gnt_o), 32'h0);
    chk("s1_ack_lat", 32'(bus.s_ack_o), 32'h0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.s_dat_i[2*DW +: DW] = beats[b];
      #1;
      chk($sformatf("s1_gnt_b%0d", b), 32'(bus.gnt_o), 32'h4);
      chk($sformatf("s1_dat_b%0d", b), 32'(bus.m_dat_o), 32'(beats[b]));
      chk($sformatf("s1_cnt_b%0d", b), 32'(bus.beat_cnt_o), 32'(b));
      chk($sformatf("s1_ack_b%0d", b), 32'(bus.s_ack_o), 32'h4);
    end
    chk("s1_tgc", 32'(bus.m_tgc_o), 32'h2);
    chk("s1_stall", 32'(bus.s_stall_o), 32'hb);
    chk("s1_cyc", 32'(bus.m_cyc_o), 32'h1);
    @(negedge clk);
    #1;
    chk("s1_b2b_gnt", 32'(bus.gnt_o), 32'h4);
    chk("s1_b2b_cnt", 32'(bus.beat_cnt_o), 32'h0);

    // Contention between sources 0 and 1.
    apply_reset();
    set_src(0, 1'b1, 8'ha0);
    set_src(1, 1'b1, 8'hb1);
    bus.m_ack_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef WISH_PACK_ARB_FIXED_PRIO_EN
      exp_w = 4'b0001;
`else
      exp_w = (g % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        #1;
        chk($sformatf("s2_gnt_g%0d_b%0d", g, b), 32'(bus.gnt_o), 32'(exp_w));
        chk($sformatf("s2_ack_g%0d_b%0d", g, b), 32'(bus.s_ack_o), 32'(exp_w));
      end
    end

    // Mid-group gap on source 1 while source 3 waits.
    apply_reset();
    set_src(1, 1'b1, 8'h51);
    bus.m_ack_i = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      #1;
      chk($sformatf("s3_cnt_b%0d", b), 32'(bus.beat_cnt_o), 32'(b));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.s_stb_i[1] = 1'b0;
      bus.m_ack_i    = 1'b0;
      set_src(3, 1'b1, 8'h73);
      #1;
      chk($sformatf("s3_gap_gnt%0d", c), 32'(bus.gnt_o), 32'h2);
      chk($sformatf("s3_gap_cnt%0d", c), 32'(bus.beat_cnt_o), 32'h2);
      chk($sformatf("s3_gap_stb%0d", c), 32'(bus.m_stb_o), 32'h0);
      chk($sformatf("s3_gap_stall%0d", c), 32'(bus.s_stall_o), 32'hd);
      chk($sformatf("s3_gap_cyc%0d", c), 32'(bus.m_cyc_o), 32'h1);
    end
    for (int b = 2; b < 4; b++) begin
      @(negedge clk);
      bus.s_stb_i[1] = 1'b1;
      bus.m_ack_i    = 1'b1;
      #1;
      chk($sformatf("s3_fin_gnt%0d", b), 32'(bus.gnt_o), 32'h2);
      chk($sformatf("s3_fin_cnt%0d", b), 32'(bus.beat_cnt_o), 32'(b));
    end
    @(negedge clk);
    #1;
`ifdef WISH_PACK_ARB_FIXED_PRIO_EN
    chk("s3_next_gnt", 32'(bus.gnt_o), 32'h2);
`else
    chk("s3_next_gnt", 32'(bus.gnt_o), 32'h8);
`endif
    chk("s3_next_cnt", 32'(bus.beat_cnt_o), 32'h0);

    // Packer stall during beat 2 of source 0.
    apply_reset();
    set_src(0, 1'b1, 8'h0f);
    bus.m_ack_i = 1'b1;
    @(negedge clk);
    #1;
    chk("s4_cnt0", 32'(bus.beat_cnt_o), 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.m_stall_i = 1'b1;
      bus.m_ack_i   = 1'b0;
      #1;
      chk($sformatf("s4_stall%0d", c), 32'(bus.s_stall_o), 32'hf);
      chk($sformatf("s4_ack%0d", c), 32'(bus.s_ack_o), 32'h0);
      chk($sformatf("s4_cnt_hold%0d", c), 32'(bus.beat_cnt_o), 32'h1);
    end
    @(negedge clk);
    bus.m_stall_i = 1'b0;
    bus.m_ack_i   = 1'b1;
    #1;
    chk("s4_resume_stall", 32'(bus.s_stall_o), 32'he);
    chk("s4_resume_cnt", 32'(bus.beat_cnt_o), 32'h1);
    @(negedge clk);
    #1;
    chk("s4_cnt2", 32'(bus.beat_cnt_o), 32'h2);

    // Async reset mid-group, then pointer restarts at source 0.
    apply_reset();
    set_src(2, 1'b1, 8'h22);
    bus.m_ack_i = 1'b1;
    for (int b = 0; b < 7; b++) begin
      @(negedge clk);
      #1;
      chk($sformatf("s5_cnt%0d", b), 32'(bus.beat_cnt_o), 32'(b % 4));
    end
    rst_n = 1'b0;
    #1;
    chk("s5_async_gnt", 32'(bus.gnt_o), 32'h0);
    chk("s5_async_cnt", 32'(bus.beat_cnt_o), 32'h0);
    chk("s5_async_stall", 32'(bus.s_stall_o), 32'hf);
    chk("s5_async_cyc", 32'(bus.m_cyc_o), 32'h0);
    set_src(2, 1'b0, 8'h00);
    set_src(1, 1'b1, 8'h61);
    set_src(3, 1'b1, 8'h63);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("s5_post_gnt", 32'(bus.gnt_o), 32'h2);
    chk("s5_post_dat", 32'(bus.m_dat_o), 32'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wish_pack_arb.md
Name: wish_pack_arb

Overview:
- Grant-locking arbiter placed in front of a single wish_pack instance. It lets NUM_SRC Wishbone classic/pipelined sources share one packer.
- A source holds the grant for exactly one complete pack group of NUM_PACK accepted beats, so words from different sources never interleave inside one packed word.
- Round-robin between sources; the master side connects directly to the packer's s_* port.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16)
- NUM_PACK, 4, beats per pack group; must match the downstream wish_pack
- DATA_WIDTH, 8, width of one beat
- TGC_WIDTH, 2, width of the cycle tag

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_stb_i  in  NUM_SRC  per-source strobe
- s_cyc_i  in  NUM_SRC  per-source cycle
- s_dat_i  in  NUM_SRC*DATA_WIDTH  per-source data; source k occupies slice k
- s_tgc_i  in  NUM_SRC*TGC_WIDTH  per-source tag; source k occupies slice k
- s_ack_o  out  NUM_SRC  per-source ack
- s_stall_o  out  NUM_SRC  per-source stall
- m_stb_o  out  1  strobe to packer
- m_cyc_o  out  1  cycle to packer
- m_dat_o  out  DATA_WIDTH  muxed data
- m_tgc_o  out  TGC_WIDTH  muxed tag
- m_ack_i  in  1  packer ack
- m_stall_i  in  1  packer stall
- gnt_o  out  NUM_SRC  one-hot current grant; 0 when idle
- beat_cnt_o  out  clog2(NUM_PACK)+1  beats accepted in the current group

Behaviour:
- Request from source k: req[k] = s_stb_i[k] & s_cyc_i[k].
- States:
  - IDLE: gnt_o=0.
  - GRANT: gnt_o one-hot, registered.
- Reset (async, rst_ni=0):
  - state IDLE, gnt_o=0, beat_cnt_o=0, rr pointer=0.
  - All outputs low except s_stall_o, which is all ones.
- Reset asserted mid-group abandons the group. The packer is expected to be reset by the same system reset.
- IDLE -> GRANT:
  - At the edge where any req is high. Winner is the first requester searching upward (with wrap) from the rr pointer.
  - Grant latency: request seen at cycle n, gnt_o valid at cycle n+1.
- In GRANT with winner g:
  - m_cyc_o=1 for the whole group, independent of s_cyc_i[g].
  - m_stb_o = s_stb_i[g] & s_cyc_i[g].
  - m_dat_o / m_tgc_o = slice g.
  - s_ack_o[g] = m_ack_i.
  - s_stall_o[g] = m_stall_i.
  - All other sources: ack=0, stall=1. The ack path is combinational, zero added latency.
- Beat accepted when m_stb_o & m_ack_i; beat_cnt_o increments.
- On the NUM_PACK-th accepted beat:
  - beat_cnt_o returns to 0 and the rr pointer becomes g+1 mod NUM_SRC.
  - Same edge re-arbitration: if any req is high (including g, which now has lowest priority), move directly to GRANT with the new winner, with no idle cycle. Otherwise go to IDLE.
- Granted source drops stb or cyc mid-group:
  - Grant and beat_cnt_o are held; m_stb_o=0. The arbiter waits for that source to finish the group.
  - Other sources remain stalled; no timeout.
- Asserted invariants: s_ack_o and s_stall_o are never both high on one source; at most one s_ack_o bit is high; gnt_o is one-hot or zero.
- When only one source requests, it is granted back-to-back with no bubbles.

Optional Feature:
- Macro: WISH_PACK_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. The rr pointer is removed and treated as constant 0. Grant locking per group is unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset then a single request: source 2 strobes 4 beats 0x11,0x22,0x33,0x44 with m_ack_i=1 every cycle -> gnt_o=0100 one cycle after the request; m_dat_o carries the 4 beats in order; beat_cnt_o counts 0..3 then 0; return to IDLE.
- Contention: sources 0 and 1 request continuously -> groups alternate 0,1,0,1; each group is exactly 4 acks with no idle cycle between groups. With WISH_PACK_ARB_FIXED_PRIO_EN defined, only source 0 is served.
- Mid-group gap: source 1 drops stb after 2 beats for 3 cycles while source 3 requests -> gnt_o stays 0010; s_stall_o[3]=1; source 1 then completes beats 3-4 before source 3 is granted.
- Packer stall: m_stall_i=1 for 2 cycles during beat 2 -> s_stall_o[g]=1, no ack, beat_cnt_o is held.
- Async reset pulse at beat 3 -> gnt_o=0, beat_cnt_o=0 and s_stall_o all ones immediately, without waiting for a clock edge. After release, the next request is granted with the pointer starting at source 0.
